ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit instantiated inside the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the latched EX operands and the M-extension funct3 when EX decodes a MUL/DIV-class instruction.
- Produces the 32-bit result after a multi-cycle computation.
- Raises a stall request so the pipeline controller freezes stall[3:0] until the result is ready.

Parameters:
XLEN, 32, operand/result width; the counter, special-case and test values below are for XLEN=32.

Ports:
clk      in   1     clock
rst      in   1     reset
start    in   1     EX holds an M-extension op; held high by the frozen ID/EX register while stalled
op       in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1      in   XLEN  operand A (dividend / multiplicand)
rs2      in   XLEN  operand B (divisor / multiplier)
annul    in   1     abort the current operation (flush)
result   out  XLEN  registered result, valid when ready=1
ready    out  1     one-cycle pulse: result valid this cycle
busy     out  1     unit not IDLE
stallreq out  1     combinational: start & ~ready & ~annul

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk, all state on posedge.
  - During reset: state=IDLE, result=0, ready=0, busy=0, counter=0, internal registers=0.
  - Reset mid-operation discards the operation; no ready pulse follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and annul=0: latch op, rs1, rs2 and sign flags.
  - Load |A| and |B| magnitudes; signed ops take the two's-complement magnitude; unsigned ops use the raw value.
  - Then go to CALC with counter=0, or go to DONE directly on a special case.
- Special cases (DIV/DIVU/REM/REMU only), resolved in the start cycle:
  - rs2=0: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=rs1.
  - DIV with rs1=0x80000000, rs2=0xFFFFFFFF: result=0x80000000. REM of the same operands: result=0.
- CALC: one radix-2 step per cycle, 32 cycles (counter 0..31). The step at counter=31 moves to DONE.
  - Multiply: shift-add on a 64-bit accumulator using magnitudes.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
- Sign fix, applied when leaving CALC and registered into result:
  - MUL takes the low 32 bits of the product.
  - MULH, MULHSU and MULHU take the high 32 bits. The 64-bit product is negated if sign(A)^sign(B).
  - MULHSU treats rs2 as unsigned.
  - Quotient is negated if sign(A)^sign(B) (DIV only). Remainder takes the sign of the dividend (REM only).
- DONE: ready=1 and busy=1 for exactly one cycle, result stable; then go to IDLE unconditionally.
- Latency, counted from the start cycle in IDLE:
  - Normal ops: ready asserted at cycle 33.
  - Special cases: ready asserted at cycle 1.
- result holds its value after DONE until the next operation completes.
- start/op/rs changes while busy are ignored; operands come only from the latch.
- Back-to-back: start=1 in the IDLE cycle following DONE begins a new operation.
  - This is the next instruction, because the pipeline advances in the DONE cycle.
- annul=1 in any state: next state IDLE, ready forced 0 that cycle and the next, stallreq=0.
  - annul and start together in IDLE: no operation starts.
- stallreq is 1 in the start cycle and through all CALC cycles. It is 0 in DONE.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> ready at cycle 33, result=0xFFFFFFEB; stallreq high cycles 0..32.
- MULH 0x80000000×0x80000000 -> result 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with ready at cycle 1:
  - DIVU x/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- Abort handling:
  - annul at CALC cycle 10 -> IDLE next cycle, no ready pulse.
  - rst asserted at cycle 20 of another op -> all outputs 0 next cycle.
  - A new start then completes normally.
- Back-to-back MUL 3×4 then DIVU 9/3 with start held -> ready pulses at cycles 33 and 67, results 12 then 3.
  - Operand changes on rs1/rs2 mid-CALC do not affect the result.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add / restoring divide.
// Latency 33 cycles from the start cycle (1 for divide special cases); stallreq holds the pipeline until ready.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            annul,
    output logic [XLEN-1:0] result,
    output logic            ready,
    output logic            busy,
    output logic            stallreq
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [2:0]        op_q;
    logic              sa_q, sb_q;
    // Multiply: opa = shifting multiplicand, opb = shifting multiplier, acc = product.
    // Divide:   opa[XLEN-1:0] = divisor, acc = {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] opa, acc, acc_nxt, prod_fix;
    logic [XLEN-1:0]   opb, quo, rmd, fin;
    logic [XLEN:0]     rem_sh, diff;

    logic              a_signed, b_signed, sa_in, sb_in, special;
    logic [XLEN-1:0]   a_mag, b_mag, sp_val;

    always_comb begin
        a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa_in    = rs1[XLEN-1] & a_signed;
        sb_in    = rs2[XLEN-1] & b_signed;
        a_mag    = sa_in ? -rs1 : rs1;
        b_mag    = sb_in ? -rs2 : rs2;
        special  = op[2] && ((rs2 == '0) ||
                   (((op == 3'b100) || (op == 3'b110)) && (rs1 == MINV) && (rs2 == '1)));
        sp_val   = (rs2 == '0) ? (op[1] ? rs1 : '1) : (op[1] ? '0 : MINV);
    end

    always_comb begin
        rem_sh = acc[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, opa[XLEN-1:0]};
        if (op_q[2]) begin
            acc_nxt = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = acc + (opb[0] ? opa : '0);
        end
        quo      = acc_nxt[XLEN-1:0];
        rmd      = acc_nxt[2*XLEN-1:XLEN];
        prod_fix = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
        case (op_q)
            3'b000:                 fin = acc_nxt[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin = (sa_q ^ sb_q) ? -quo : quo;
            default:                fin = sa_q ? -rmd : rmd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            op_q   <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            result <= '0;
        end else if (annul) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        sa_q  <= sa_in;
                        sb_q  <= sb_in;
                        opa   <= {{XLEN{1'b0}}, op[2] ? b_mag : a_mag};
                        opb   <= b_mag;
                        acc   <= op[2] ? {{XLEN{1'b0}}, a_mag} : '0;
                        count <= '0;
                        if (special) begin
                            result <= sp_val;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc   <= acc_nxt;
                    count <= count + 1'b1;
                    if (!op_q[2]) begin
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end
                    if (count == CW'(XLEN - 1)) begin
                        result <= fin;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready    = (state == S_DONE) & ~annul;
    assign busy     = (state != S_IDLE);
    assign stallreq = start & ~ready & ~annul;
endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed checks of ex_muldiv against a plain-arithmetic RV32M reference.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst, start, annul;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, result;
    logic        ready, busy, stallreq;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
        .annul(annul), .result(result), .ready(ready), .busy(busy), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    int          ncyc = 0, n_done = 0, last_ready_cyc = 0;
    int          start_cyc = 0, exp_lat = 0;
    bit          pend = 1'b0;
    logic [31:0] exp_res = '0, last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: RV32M semantics straight from signed/unsigned 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (o)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 0) || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Single compare process: checks every cycle while an op is in flight, and idle cycles for stray ready.
    always @(negedge clk) begin
        if (!rst) begin
            if (pend) begin
                chk("busy", 32'(busy), 32'(ncyc != start_cyc));
                chk("stallreq", 32'(stallreq), 32'((ncyc - start_cyc) < exp_lat));
                if (ready) begin
                    chk("latency", 32'(ncyc - start_cyc), 32'(exp_lat));
                    chk("result", result, exp_res);
                    last_ready_cyc = ncyc;
                    n_done++;
                end
            end else begin
                chk("idle_ready", 32'(ready), 32'd0);
            end
        end
        ncyc++;
    end

    // Issue one op from an IDLE cycle; holds start like a stalled ID/EX register, scrambles operands mid-CALC.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input bit keep);
        int d0;
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        exp_res = e;
        exp_lat = is_special(o, a, b) ? 1 : 33;
        start_cyc = ncyc;
        d0 = n_done;
        pend = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (n_done != d0) break;
            if (i == 4) begin
                rs1 = $urandom; rs2 = $urandom; op = 3'($urandom);
            end
        end
        if (n_done == d0) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: no ready for op %0d, expected ready at cycle %0d", o, exp_lat);
        end
        pend = 1'b0;
        last_res = e;
        if (!keep) start = 1'b0;
    endtask

    task automatic lit(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e);
        chk(name, model(o, a, b), e);
        do_op(o, a, b, e, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          base;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; annul = 1'b0; op = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        lit("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        lit("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        lit("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        lit("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        lit("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        lit("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        lit("divu", 3'd5, 32'd100, 32'd7, 32'd14);
        lit("remu", 3'd7, 32'd100, 32'd7, 32'd2);
        lit("divu0", 3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        lit("rem0", 3'd6, 32'd5, 32'd0, 32'd5);
        lit("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        lit("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Annul at CALC counter 10: back to IDLE, no ready, result untouched.
        op = 3'd0; rs1 = 32'd11; rs2 = 32'd13; start = 1'b1;
        repeat (11) @(posedge clk); #1;
        annul = 1'b1;
        @(negedge clk);
        chk("annul_stall", 32'(stallreq), 32'd0);
        chk("annul_busy_same", 32'(busy), 32'd1);
        @(posedge clk); #1 annul = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("annul_idle", 32'(busy), 32'd0);
        repeat (40) @(posedge clk); #1;
        chk("annul_hold", result, last_res);

        // Reset 20 cycles into a divide: everything clears, no ready follows.
        op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        repeat (20) @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rrst_result", result, 32'd0);
        chk("rrst_ready", 32'(ready), 32'd0);
        chk("rrst_busy", 32'(busy), 32'd0);
        chk("rrst_stall", 32'(stallreq), 32'd0);
        repeat (40) @(posedge clk); #1;
        do_op(3'd5, 32'd1000, 32'd3, model(3'd5, 32'd1000, 32'd3), 1'b0);
        chk("after_rst", model(3'd5, 32'd1000, 32'd3), 32'd333);

        // Back-to-back with start held across DONE.
        base = ncyc;
        do_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b1);
        chk("b2b_first", 32'(last_ready_cyc - base), 32'd33);
        do_op(3'd5, 32'd9, 32'd3, 32'd3, 1'b0);
        chk("b2b_second", 32'(last_ready_cyc - base), 32'd67);
        repeat (3) @(posedge clk); #1;
        chk("result_hold", result, 32'd3);

        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom);
            ra = pick();
            rb = pick();
            do_op(ro, ra, rb, model(ro, ra, rb), 1'($urandom));
        end
        start = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
